bin2bcd_seq: RTL and testbench

- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly upstream of the seven-segment digit decoders on the DE2 board. A binary count or value goes in; it returns DIGITS packed BCD nibbles, one per HEX display.
- Output holds between conversions so the displays stay stable.

---
 rtl/bin2bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
// The result registers hold between conversions so the downstream HEX displays stay stable.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one add-3/shift step per edge, BIN_W edges in total
// DONE  | publish bcd_out/overflow, pulse done, drop busy
`timescale 1ns/1ps

module bin2bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    // Largest value representable in DIGITS decimal digits, folded at elaboration.
    function automatic logic [63:0] max_decimal(input int digits);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < digits; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_decimal(DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   work_adj;
    logic [WORK_W-1:0]   work_shift;
    logic [CNT_W-1:0]    cnt;
    logic                ovf;
    logic                ovf_in;

    assign ovf_in = (64'(bin_in) > MAX_VAL);

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the last shift is the one that takes cnt from 1 to 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add 3 to every BCD nibble that is 5 or more (no inter-nibble carry), then shift left.
    always_comb begin
        work_adj = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[BIN_W + 4*k +: 4] >= 4'd5) begin
                work_adj[BIN_W + 4*k +: 4] = work[BIN_W + 4*k +: 4] + 4'd3;
            end
        end
        work_shift = work_adj << 1;
    end

    // Datapath and output registers; reset clears everything, aborting any conversion silently.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            work     <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= {{BCD_W{1'b0}}, bin_in};
                        cnt  <= CNT_W'(BIN_W);
                        ovf  <= ovf_in;
                        busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    work <= work_shift;
                    cnt  <= cnt - CNT_W'(1);
                end
                DONE: begin
                    bcd_out  <= ovf ? {DIGITS{4'h9}} : work[WORK_W-1 -: BCD_W];
                    overflow <= ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: table-driven conversions plus hand-written multi-cycle sequences.
`timescale 1ns/1ps

module tb_bin2bcd_seq;

    logic        CLOCK_50;
    logic        RESET_N;
    logic        start;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    bin2bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    // Advance past the next rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full conversion: latency, busy profile, result, and done width.
    task automatic run_conv(input string name, input logic [26:0] v, input logic [31:0] exp_bcd,
                            input logic exp_ovf, input bit scramble);
        int n;
        bit got;
        bit busy_ok;
        bin_in = v;
        start  = 1'b1;
        tick();
        start   = 1'b0;
        n       = 0;
        got     = 0;
        busy_ok = (busy === 1'b1);
        while (!got && n < 40) begin
            if (scramble && n == 3) bin_in = 27'h5A5A5A5;
            tick();
            n++;
            if (done === 1'b1) got = 1;
            else if (busy !== 1'b1) busy_ok = 0;
        end
        check({name, " latency"}, 64'(n), 64'd28);
        check({name, " busy_during"}, 64'(busy_ok), 64'd1);
        check({name, " bcd"}, 64'(bcd_out), 64'(exp_bcd));
        check({name, " ovf"}, 64'(overflow), 64'(exp_ovf));
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
        tick();
        check({name, " done_width"}, 64'(done), 64'd0);
        check({name, " bcd_hold"}, 64'(bcd_out), 64'(exp_bcd));
    endtask

    initial begin : main
        int dones;
        int done_cycle;
        int done_cycles[$];

        vecs[0] = '{27'd0,         32'h00000000, 1'b0};
        vecs[1] = '{27'h0BC614E,   32'h12345678, 1'b0};
        vecs[2] = '{27'd99999999,  32'h99999999, 1'b0};
        vecs[3] = '{27'd100000000, 32'h99999999, 1'b1};
        vecs[4] = '{27'd7,         32'h00000007, 1'b0};
        vecs[5] = '{27'd1,         32'h00000001, 1'b0};
        vecs[6] = '{27'd9,         32'h00000009, 1'b0};
        vecs[7] = '{27'd10,        32'h00000010, 1'b0};
        vecs[8] = '{27'd99,        32'h00000099, 1'b0};
        vecs[9] = '{27'h7FFFFFF,   32'h99999999, 1'b1};

        RESET_N = 1'b0;
        start   = 1'b0;
        bin_in  = '0;
        tick();
        tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset bcd", 64'(bcd_out), 64'd0);
        check("reset ovf", 64'(overflow), 64'd0);
        RESET_N = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf, 1'b0);
        end

        // bin_in changes during SHIFT must not affect the result.
        run_conv("scramble", 27'h0BC614E, 32'h12345678, 1'b0, 1'b1);

        // Starts while busy are ignored, not queued.
        bin_in = 27'd321;
        start  = 1'b1;
        tick();
        dones      = 0;
        done_cycle = -1;
        for (int n = 1; n <= 60; n++) begin
            start  = (n == 5 || n == 27);
            bin_in = start ? 27'd999 : 27'd321;
            tick();
            if (done === 1'b1) begin
                dones++;
                done_cycle = n;
            end
        end
        start = 1'b0;
        check("busy_start dones", 64'(dones), 64'd1);
        check("busy_start cycle", 64'(done_cycle), 64'd28);
        check("busy_start bcd", 64'(bcd_out), 64'h321);

        // Held start restarts on the edge after done; done every 29 cycles.
        bin_in = 27'd42;
        start  = 1'b1;
        tick();
        for (int n = 1; n <= 86; n++) begin
            tick();
            if (done === 1'b1) done_cycles.push_back(n);
        end
        start = 1'b0;
        check("held count", 64'(done_cycles.size()), 64'd3);
        if (done_cycles.size() == 3) begin
            check("held first", 64'(done_cycles[0]), 64'd28);
            check("held period1", 64'(done_cycles[1] - done_cycles[0]), 64'd29);
            check("held period2", 64'(done_cycles[2] - done_cycles[1]), 64'd29);
        end
        check("held bcd", 64'(bcd_out), 64'h42);
        tick();
        check("held idle", 64'(busy), 64'd0);

        // Reset at cycle 10 of a conversion aborts silently.
        bin_in = 27'd555;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 9; n++) tick();
        RESET_N = 1'b0;
        tick();
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort bcd", 64'(bcd_out), 64'd0);
        check("abort ovf", 64'(overflow), 64'd0);
        RESET_N = 1'b1;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("abort no_done", 64'(dones), 64'd0);
        check("abort bcd_stays", 64'(bcd_out), 64'd0);
        run_conv("after_abort", 27'd555, 32'h00000555, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
